// File: rtl/otter_pkg.sv
// Shared definitions for the decode stage: opcodes, ALU codes, mux selects and the ID/EX control bundle.
// Latency: n/a (definitions only).
// Backpressure: n/a. Also holds the helpers that say which opcodes read rs1/rs2.
package otter_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_fun_t;

    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_PC   = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    localparam logic       SRCB_RS2  = 1'b0;
    localparam logic       SRCB_IMM  = 1'b1;

    localparam logic [1:0] WR_ALU    = 2'd0;
    localparam logic [1:0] WR_MEM    = 2'd1;
    localparam logic [1:0] WR_PC4    = 2'd2;

    // alu_fun is a plain vector: OP instructions pass {ir[30],funct3}
    // straight through, which can land on codes outside alu_fun_t.
    typedef struct packed {
        logic [3:0] alu_fun;
        logic [1:0] srca_sel;
        logic       srcb_sel;
        logic [1:0] rf_wr_sel;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
    } idex_ctrl_t;

    function automatic logic uses_rs1(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file, x0 hard-wired to zero, writeback-to-read bypass.
// Latency: reads combinational, writes land on the next posedge CLOCK.
// Backpressure: none. Ports: i_we/i_wa/i_wd write port, i_ra1/i_ra2 -> o_rd1/o_rd2 read ports.
module reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic            i_we,
    input  logic [4:0]      i_wa,
    input  logic [XLEN-1:0] i_wd,
    input  logic [4:0]      i_ra1,
    input  logic [4:0]      i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);

    logic [XLEN-1:0] r_mem [NREGS];
    logic            w_wr_ok;
    logic            w_byp1;
    logic            w_byp2;

    assign w_wr_ok = i_we && (i_wa != 5'd0);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Same-cycle writeback is forwarded so decode never sees a stale value.
    assign w_byp1 = w_wr_ok && (i_wa == i_ra1);
    assign w_byp2 = w_wr_ok && (i_wa == i_ra2);

    assign o_rd1 = (i_ra1 == 5'd0) ? '0 : (w_byp1 ? i_wd : r_mem[i_ra1]);
    assign o_rd2 = (i_ra2 == 5'd0) ? '0 : (w_byp2 ? i_wd : r_mem[i_ra2]);

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: register read, immediate generation, control decode, load-use stall, ID/EX register.
// Latency: 1 cycle IF/ID -> ID/EX; every ID/EX field reloads on every posedge CLOCK.
// Backpressure: PC_WRITE/IF_ID_WRITE drop for one cycle on a load-use hazard; FLUSH overrides the stall.
// Ports: IF_ID_* in from fetch, WB_* writeback, FLUSH from execute, ID_EX_* registered out.
module decode_stage
    import otter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic [31:0]     IF_ID_IR,
    input  logic [XLEN-1:0] IF_ID_PC,
    input  logic [XLEN-1:0] IF_ID_PC_4,
    input  logic            FLUSH,
    input  logic            WB_WE,
    input  logic [4:0]      WB_RD,
    input  logic [XLEN-1:0] WB_DATA,
    output logic            PC_WRITE,
    output logic            IF_ID_WRITE,
    output logic [XLEN-1:0] ID_EX_PC,
    output logic [XLEN-1:0] ID_EX_PC_4,
    output logic [XLEN-1:0] ID_EX_RS1_DATA,
    output logic [XLEN-1:0] ID_EX_RS2_DATA,
    output logic [XLEN-1:0] ID_EX_IMM,
    output logic [4:0]      ID_EX_RS1,
    output logic [4:0]      ID_EX_RS2,
    output logic [4:0]      ID_EX_RD,
    output logic [2:0]      ID_EX_FUNCT3,
    output logic [3:0]      ID_EX_ALU_FUN,
    output logic [1:0]      ID_EX_SRCA_SEL,
    output logic            ID_EX_SRCB_SEL,
    output logic [1:0]      ID_EX_RF_WR_SEL,
    output logic            ID_EX_REG_WRITE,
    output logic            ID_EX_MEM_READ,
    output logic            ID_EX_MEM_WRITE,
    output logic            ID_EX_BRANCH,
    output logic            ID_EX_JUMP
);

    logic [6:0]      w_opc;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic [XLEN-1:0] w_imm;
    idex_ctrl_t      w_ctrl;
    idex_ctrl_t      w_ctrl_nxt;
    logic            w_stall;
    logic            w_bubble;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_4;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [2:0]      r_f3;
    idex_ctrl_t      r_ctrl;

    assign w_opc = IF_ID_IR[6:0];
    assign w_rd  = IF_ID_IR[11:7];
    assign w_f3  = IF_ID_IR[14:12];
    assign w_rs1 = IF_ID_IR[19:15];
    assign w_rs2 = IF_ID_IR[24:20];

    reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .i_we  (WB_WE),
        .i_wa  (WB_RD),
        .i_wd  (WB_DATA),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .o_rd1 (w_rs1_data),
        .o_rd2 (w_rs2_data)
    );

    // Immediate generator; opcodes without an immediate yield zero.
    always_comb begin
        w_imm = '0;
        case (w_opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                w_imm = {{20{IF_ID_IR[31]}}, IF_ID_IR[31:20]};
            OPC_STORE:
                w_imm = {{20{IF_ID_IR[31]}}, IF_ID_IR[31:25], IF_ID_IR[11:7]};
            OPC_BRANCH:
                w_imm = {{20{IF_ID_IR[31]}}, IF_ID_IR[7], IF_ID_IR[30:25], IF_ID_IR[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                w_imm = {IF_ID_IR[31:12], 12'b0};
            OPC_JAL:
                w_imm = {{12{IF_ID_IR[31]}}, IF_ID_IR[19:12], IF_ID_IR[20], IF_ID_IR[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // Main control decoder; unknown opcodes decode to an all-zero bubble.
    always_comb begin
        w_ctrl = '0;
        case (w_opc)
            OPC_OP: begin
                w_ctrl.alu_fun   = {IF_ID_IR[30], w_f3};
                w_ctrl.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                // ir[30] selects SRA over SRL only; elsewhere it is immediate bits.
                w_ctrl.alu_fun   = {(w_f3 == 3'b101) ? IF_ID_IR[30] : 1'b0, w_f3};
                w_ctrl.srcb_sel  = SRCB_IMM;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_LUI: begin
                w_ctrl.srca_sel  = SRCA_ZERO;
                w_ctrl.srcb_sel  = SRCB_IMM;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                w_ctrl.srca_sel  = SRCA_PC;
                w_ctrl.srcb_sel  = SRCB_IMM;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                w_ctrl.srcb_sel  = SRCB_IMM;
                w_ctrl.rf_wr_sel = WR_MEM;
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_STORE: begin
                w_ctrl.srcb_sel  = SRCB_IMM;
                w_ctrl.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                w_ctrl.branch    = 1'b1;
            end
            OPC_JAL: begin
                w_ctrl.srca_sel  = SRCA_PC;
                w_ctrl.srcb_sel  = SRCB_IMM;
                w_ctrl.rf_wr_sel = WR_PC4;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
            end
            OPC_JALR: begin
                w_ctrl.srcb_sel  = SRCB_IMM;
                w_ctrl.rf_wr_sel = WR_PC4;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    // Load-use hazard: the load in EX has not produced its data yet. The
    // bubble it inserts clears ID_EX_MEM_READ, so the stall self-limits to one cycle.
    assign w_stall = r_ctrl.mem_read && (r_rd != 5'd0) &&
                     (((r_rd == w_rs1) && uses_rs1(w_opc)) ||
                      ((r_rd == w_rs2) && uses_rs2(w_opc)));

    // A taken branch discards the instruction being decoded, so holding fetch would be wrong.
    assign PC_WRITE    = FLUSH || !w_stall;
    assign IF_ID_WRITE = FLUSH || !w_stall;
    assign w_bubble    = FLUSH || w_stall;

    always_comb begin
        w_ctrl_nxt = w_ctrl;
        if (w_bubble) begin
            w_ctrl_nxt.reg_write = 1'b0;
            w_ctrl_nxt.mem_read  = 1'b0;
            w_ctrl_nxt.mem_write = 1'b0;
            w_ctrl_nxt.branch    = 1'b0;
            w_ctrl_nxt.jump      = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_pc       <= '0;
            r_pc_4     <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_f3       <= '0;
            r_ctrl     <= '0;
        end else begin
            r_pc       <= IF_ID_PC;
            r_pc_4     <= IF_ID_PC_4;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_imm      <= w_imm;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_rd       <= w_rd;
            r_f3       <= w_f3;
            r_ctrl     <= w_ctrl_nxt;
        end
    end

    assign ID_EX_PC        = r_pc;
    assign ID_EX_PC_4      = r_pc_4;
    assign ID_EX_RS1_DATA  = r_rs1_data;
    assign ID_EX_RS2_DATA  = r_rs2_data;
    assign ID_EX_IMM       = r_imm;
    assign ID_EX_RS1       = r_rs1;
    assign ID_EX_RS2       = r_rs2;
    assign ID_EX_RD        = r_rd;
    assign ID_EX_FUNCT3    = r_f3;
    assign ID_EX_ALU_FUN   = r_ctrl.alu_fun;
    assign ID_EX_SRCA_SEL  = r_ctrl.srca_sel;
    assign ID_EX_SRCB_SEL  = r_ctrl.srcb_sel;
    assign ID_EX_RF_WR_SEL = r_ctrl.rf_wr_sel;
    assign ID_EX_REG_WRITE = r_ctrl.reg_write;
    assign ID_EX_MEM_READ  = r_ctrl.mem_read;
    assign ID_EX_MEM_WRITE = r_ctrl.mem_write;
    assign ID_EX_BRANCH    = r_ctrl.branch;
    assign ID_EX_JUMP      = r_ctrl.jump;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: decode vector table, then hazard/flush/reset sequences.
// Latency: checks ID/EX one cycle after each instruction is presented.
// Backpressure: PC_WRITE/IF_ID_WRITE checked before each edge.
module tb_decode_stage;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [31:0] IF_ID_IR, IF_ID_PC, IF_ID_PC_4;
    logic        FLUSH, WB_WE;
    logic [4:0]  WB_RD;
    logic [31:0] WB_DATA;
    logic        PC_WRITE, IF_ID_WRITE;
    logic [31:0] ID_EX_PC, ID_EX_PC_4, ID_EX_RS1_DATA, ID_EX_RS2_DATA, ID_EX_IMM;
    logic [4:0]  ID_EX_RS1, ID_EX_RS2, ID_EX_RD;
    logic [2:0]  ID_EX_FUNCT3;
    logic [3:0]  ID_EX_ALU_FUN;
    logic [1:0]  ID_EX_SRCA_SEL, ID_EX_RF_WR_SEL;
    logic        ID_EX_SRCB_SEL;
    logic        ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_JUMP;
    logic [4:0]  ctl;

    int n_vec = 0;
    int n_err = 0;

    assign ctl = {ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_JUMP};

    always #5 CLOCK = ~CLOCK;

    decode_stage dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .IF_ID_IR(IF_ID_IR), .IF_ID_PC(IF_ID_PC), .IF_ID_PC_4(IF_ID_PC_4),
        .FLUSH(FLUSH), .WB_WE(WB_WE), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
        .PC_WRITE(PC_WRITE), .IF_ID_WRITE(IF_ID_WRITE),
        .ID_EX_PC(ID_EX_PC), .ID_EX_PC_4(ID_EX_PC_4),
        .ID_EX_RS1_DATA(ID_EX_RS1_DATA), .ID_EX_RS2_DATA(ID_EX_RS2_DATA),
        .ID_EX_IMM(ID_EX_IMM), .ID_EX_RS1(ID_EX_RS1), .ID_EX_RS2(ID_EX_RS2),
        .ID_EX_RD(ID_EX_RD), .ID_EX_FUNCT3(ID_EX_FUNCT3), .ID_EX_ALU_FUN(ID_EX_ALU_FUN),
        .ID_EX_SRCA_SEL(ID_EX_SRCA_SEL), .ID_EX_SRCB_SEL(ID_EX_SRCB_SEL),
        .ID_EX_RF_WR_SEL(ID_EX_RF_WR_SEL), .ID_EX_REG_WRITE(ID_EX_REG_WRITE),
        .ID_EX_MEM_READ(ID_EX_MEM_READ), .ID_EX_MEM_WRITE(ID_EX_MEM_WRITE),
        .ID_EX_BRANCH(ID_EX_BRANCH), .ID_EX_JUMP(ID_EX_JUMP)
    );

    typedef struct {
        logic [31:0] ir;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [31:0] imm;
        logic        chk_imm;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [1:0]  srca;
        logic        srcb;
        logic [1:0]  wrsel;
        logic [4:0]  ctl;   // {reg_write, mem_read, mem_write, branch, jump}
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic [31:0] ir, input logic we, input logic [4:0] wrd,
                                input logic [31:0] wdata, input logic [31:0] imm, input logic chk_imm,
                                input logic [31:0] rs1d, input logic [31:0] rs2d, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [3:0] alu, input logic [1:0] srca,
                                input logic srcb, input logic [1:0] wrsel, input logic [4:0] c);
        vec_t v;
        v.ir = ir; v.we = we; v.wrd = wrd; v.wdata = wdata; v.imm = imm; v.chk_imm = chk_imm;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rd = rd; v.f3 = f3; v.alu = alu; v.srca = srca;
        v.srcb = srcb; v.wrsel = wrsel; v.ctl = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one instruction, check the fetch-control outputs before the edge, then clock it in.
    task automatic issue(input logic [31:0] ir, input logic flush, input logic exp_wr);
        @(negedge CLOCK);
        IF_ID_IR = ir; FLUSH = flush; WB_WE = 1'b0;
        #1;
        chk("pc_write", {31'b0, PC_WRITE}, {31'b0, exp_wr});
        chk("if_id_write", {31'b0, IF_ID_WRITE}, {31'b0, exp_wr});
        @(posedge CLOCK); #1;
        n_vec++;
    endtask

    localparam logic [31:0] LW_X2    = 32'h0000A103;  // lw   x2,0(x1)
    localparam logic [31:0] ADD_322  = 32'h002101B3;  // add  x3,x2,x2
    localparam logic [31:0] SW_X2    = 32'h00202023;  // sw   x2,0(x0)
    localparam logic [31:0] LUI_RS2  = 32'h00010637;  // lui  x12,0x10 (rs1 field = 2)
    localparam logic [31:0] LW_X0    = 32'h0000A003;  // lw   x0,0(x1)
    localparam logic [31:0] ADD_300  = 32'h000001B3;  // add  x3,x0,x0
    localparam logic [31:0] ADD_433  = 32'h00318233;  // add  x4,x3,x3
    localparam logic [31:0] ADDI_M1  = 32'hFFF00093;  // addi x1,x0,-1
    localparam logic [31:0] DB       = 32'hDEADBEEF;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = mk(32'h00528333, 0, 0, 0,          32'h0,        1, 0,  0,  6,  0, 4'b0000, 0, 0, 0, 5'b10000); // add x6,x5,x5
        tbl[1]  = mk(32'hFFF00093, 0, 0, 0,          32'hFFFFFFFF, 1, 0,  0,  1,  0, 4'b0000, 0, 1, 0, 5'b10000); // addi x1,x0,-1
        tbl[2]  = mk(32'h00318233, 1, 3, DB,         32'h0,        1, DB, DB, 4,  0, 4'b0000, 0, 0, 0, 5'b10000); // add x4,x3,x3 + bypass
        tbl[3]  = mk(32'h00018233, 1, 0, 32'h12345678, 32'h0,      1, DB, 0,  4,  0, 4'b0000, 0, 0, 0, 5'b10000); // add x4,x3,x0; WB to x0
        tbl[4]  = mk(32'h403183B3, 0, 0, 0,          32'h0,        1, DB, DB, 7,  0, 4'b1000, 0, 0, 0, 5'b10000); // sub
        tbl[5]  = mk(32'h4041D413, 0, 0, 0,          32'h00000404, 1, DB, 0,  8,  5, 4'b1101, 0, 1, 0, 5'b10000); // srai
        tbl[6]  = mk(32'h40000493, 0, 0, 0,          32'h00000400, 1, 0,  0,  9,  0, 4'b0000, 0, 1, 0, 5'b10000); // addi, ir[30]=1
        tbl[7]  = mk(32'h12345537, 0, 0, 0,          32'h12345000, 1, 0,  DB, 10, 5, 4'b0000, 2, 1, 0, 5'b10000); // lui
        tbl[8]  = mk(32'hFFFFF597, 0, 0, 0,          32'hFFFFF000, 1, 0,  0,  11, 7, 4'b0000, 1, 1, 0, 5'b10000); // auipc
        tbl[9]  = mk(32'hFE31AE23, 0, 0, 0,          32'hFFFFFFFC, 1, DB, DB, 28, 2, 4'b0000, 0, 1, 0, 5'b00100); // sw
        tbl[10] = mk(32'h000180E3, 0, 0, 0,          32'h00000800, 1, DB, 0,  1,  0, 4'b0000, 0, 0, 0, 5'b00010); // beq
        tbl[11] = mk(32'h803000EF, 0, 0, 0,          32'hFFF00802, 1, 0,  DB, 1,  0, 4'b0000, 1, 1, 2, 5'b10001); // jal
        tbl[12] = mk(32'h010182E7, 0, 0, 0,          32'h00000010, 1, DB, 0,  5,  0, 4'b0000, 0, 1, 2, 5'b10001); // jalr
        tbl[13] = mk(32'hFFFFFFFF, 0, 0, 0,          32'h0,        0, 0,  0,  31, 7, 4'b0000, 0, 0, 0, 5'b00000); // invalid

        RESET = 1'b1; IF_ID_IR = '0; IF_ID_PC = '0; IF_ID_PC_4 = '0;
        FLUSH = 1'b0; WB_WE = 1'b0; WB_RD = '0; WB_DATA = '0;
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        #1;
        chk("rst_pc", ID_EX_PC, 0);
        chk("rst_pc4", ID_EX_PC_4, 0);
        chk("rst_rs1d", ID_EX_RS1_DATA, 0);
        chk("rst_rs2d", ID_EX_RS2_DATA, 0);
        chk("rst_imm", ID_EX_IMM, 0);
        chk("rst_fields", {7'b0, ID_EX_RS1, ID_EX_RS2, ID_EX_RD, ID_EX_FUNCT3, ID_EX_ALU_FUN,
                           ID_EX_SRCA_SEL, ID_EX_SRCB_SEL, ID_EX_RF_WR_SEL}, 0);
        chk("rst_ctl", {27'b0, ctl}, 0);
        chk("rst_pc_write", {31'b0, PC_WRITE}, 1);
        chk("rst_if_id_write", {31'b0, IF_ID_WRITE}, 1);
        n_vec++;

        for (int i = 0; i < 14; i++) begin
            @(negedge CLOCK);
            IF_ID_IR   = tbl[i].ir;
            IF_ID_PC   = 32'h1000 + 32'(i) * 4;
            IF_ID_PC_4 = 32'h1004 + 32'(i) * 4;
            WB_WE = tbl[i].we; WB_RD = tbl[i].wrd; WB_DATA = tbl[i].wdata;
            FLUSH = 1'b0;
            #1;
            chk($sformatf("v%0d pc_write", i), {31'b0, PC_WRITE}, 1);
            @(posedge CLOCK); #1;
            chk($sformatf("v%0d pc", i), ID_EX_PC, 32'h1000 + 32'(i) * 4);
            chk($sformatf("v%0d pc4", i), ID_EX_PC_4, 32'h1004 + 32'(i) * 4);
            if (tbl[i].chk_imm) chk($sformatf("v%0d imm", i), ID_EX_IMM, tbl[i].imm);
            chk($sformatf("v%0d rs1d", i), ID_EX_RS1_DATA, tbl[i].rs1d);
            chk($sformatf("v%0d rs2d", i), ID_EX_RS2_DATA, tbl[i].rs2d);
            chk($sformatf("v%0d rd", i), {27'b0, ID_EX_RD}, {27'b0, tbl[i].rd});
            chk($sformatf("v%0d f3", i), {29'b0, ID_EX_FUNCT3}, {29'b0, tbl[i].f3});
            chk($sformatf("v%0d alu", i), {28'b0, ID_EX_ALU_FUN}, {28'b0, tbl[i].alu});
            chk($sformatf("v%0d sel", i), {27'b0, ID_EX_SRCA_SEL, ID_EX_SRCB_SEL, ID_EX_RF_WR_SEL},
                {27'b0, tbl[i].srca, tbl[i].srcb, tbl[i].wrsel});
            chk($sformatf("v%0d ctl", i), {27'b0, ctl}, {27'b0, tbl[i].ctl});
            n_vec++;
        end

        // Load-use on rs1/rs2: one-cycle hold, bubble, then the consumer issues.
        issue(LW_X2, 1'b0, 1'b1);
        chk("lw ctl", {27'b0, ctl}, {27'b0, 5'b11000});
        chk("lw rd/wrsel", {25'b0, ID_EX_RD, ID_EX_RF_WR_SEL}, {25'b0, 5'd2, 2'd1});
        issue(ADD_322, 1'b0, 1'b0);
        chk("lu bubble ctl", {27'b0, ctl}, 0);
        issue(ADD_322, 1'b0, 1'b1);
        chk("lu issue ctl", {27'b0, ctl}, {27'b0, 5'b10000});
        chk("lu issue rd", {27'b0, ID_EX_RD}, 3);

        // Store depends on rs2 only.
        issue(LW_X2, 1'b0, 1'b1);
        issue(SW_X2, 1'b0, 1'b0);
        chk("sw bubble ctl", {27'b0, ctl}, 0);
        issue(SW_X2, 1'b0, 1'b1);
        chk("sw issue ctl", {27'b0, ctl}, {27'b0, 5'b00100});

        // LUI does not read rs1 even when its bits match the load rd.
        issue(LW_X2, 1'b0, 1'b1);
        issue(LUI_RS2, 1'b0, 1'b1);
        chk("lui no stall ctl", {27'b0, ctl}, {27'b0, 5'b10000});

        // Load into x0 never stalls.
        issue(LW_X0, 1'b0, 1'b1);
        issue(ADD_300, 1'b0, 1'b1);
        chk("x0 load ctl", {27'b0, ctl}, {27'b0, 5'b10000});

        // Stall and flush together: flush wins, bubble enters.
        issue(LW_X2, 1'b0, 1'b1);
        issue(ADD_322, 1'b1, 1'b1);
        chk("stall+flush ctl", {27'b0, ctl}, 0);
        issue(ADD_322, 1'b0, 1'b1);
        chk("after flush ctl", {27'b0, ctl}, {27'b0, 5'b10000});

        // Flush alone: control squashed, data still latched.
        issue(ADDI_M1, 1'b1, 1'b1);
        chk("flush ctl", {27'b0, ctl}, 0);
        chk("flush imm", ID_EX_IMM, 32'hFFFFFFFF);

        // Reset in the middle of a stall clears the stall and the register file.
        issue(ADD_433, 1'b0, 1'b1);
        chk("pre-reset x3", ID_EX_RS1_DATA, DB);
        issue(LW_X2, 1'b0, 1'b1);
        @(negedge CLOCK);
        IF_ID_IR = ADD_322; RESET = 1'b1;
        #1;
        chk("stall before reset", {31'b0, PC_WRITE}, 0);
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        #1;
        chk("reset clears stall", {31'b0, PC_WRITE}, 1);
        chk("reset clears stall ifid", {31'b0, IF_ID_WRITE}, 1);
        chk("reset ctl", {27'b0, ctl}, 0);
        chk("reset rd", {27'b0, ID_EX_RD}, 0);
        n_vec++;
        issue(ADD_433, 1'b0, 1'b1);
        chk("post-reset x3", ID_EX_RS1_DATA, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode pipeline stage; sits directly downstream of the fetch stage and consumes its IF/ID outputs (instruction word, PC, PC+4).
- Contains the 32x32 register file, immediate generator, main control decoder, load-use hazard unit and the ID/EX pipeline register.
- Drives PC_WRITE and IF_ID_WRITE back to fetch for stalls.
- Accepts a flush from execute when a branch or jump is taken.

Parameters:
XLEN, 32, datapath width
NREGS, 32, register-file depth (x0 hard-wired zero)

Ports:
CLOCK  in  1  clock, all state on posedge
RESET  in  1  synchronous, active-high reset
IF_ID_IR  in  32  instruction word from fetch
IF_ID_PC  in  32  PC of that instruction
IF_ID_PC_4  in  32  PC+4 of that instruction
FLUSH  in  1  taken branch/jump in EX; squash the decoding instruction
WB_WE  in  1  writeback enable
WB_RD  in  5  writeback destination
WB_DATA  in  32  writeback data
PC_WRITE  out  1  to fetch: 0 = hold PC
IF_ID_WRITE  out  1  to fetch: 0 = hold IF/ID register
ID_EX_PC, ID_EX_PC_4  out  32 each  registered PC, PC+4
ID_EX_RS1_DATA, ID_EX_RS2_DATA  out  32 each  registered operands
ID_EX_IMM  out  32  registered sign-extended immediate
ID_EX_RS1, ID_EX_RS2, ID_EX_RD  out  5 each  register addresses (forwarding)
ID_EX_FUNCT3  out  3  branch/load/store size
ID_EX_ALU_FUN  out  4  ALU operation
ID_EX_SRCA_SEL  out  2  0=rs1, 1=PC, 2=zero
ID_EX_SRCB_SEL  out  1  0=rs2, 1=imm
ID_EX_RF_WR_SEL  out  2  0=ALU, 1=memory, 2=PC+4
ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_JUMP  out  1 each  control

Behaviour:
- Reset: all ID_EX_* outputs 0 (a bubble); all 32 registers cleared; PC_WRITE and IF_ID_WRITE read 1 once RESET deasserts. Reset mid-stall also clears the stall.
- Register file:
  - Write on posedge when WB_WE and WB_RD!=0.
  - Reads are combinational.
  - Internal bypass: if WB_WE && WB_RD!=0 && WB_RD==rsX, read returns WB_DATA in the same cycle.
  - x0 always reads 0.
- Immediate (from IR bits), by opcode:
  - I-type: LOAD, OP_IMM, JALR
  - S-type: STORE
  - B-type: BRANCH
  - U-type: LUI, AUIPC, value {ir[31:12],12'b0}
  - J-type: JAL
  - All sign-extended from ir[31].
- Control (opcode IR[6:0]):
  - OP 0110011: srcA rs1, srcB rs2, alu_fun={ir[30],f3}, reg_write.
  - OP_IMM 0010011: srcB imm; alu_fun={f3==101?ir[30]:0, f3}.
  - LUI 0110111: srcA zero, srcB imm, add (0000).
  - AUIPC 0010111: srcA PC, srcB imm, add.
  - LOAD 0000011: add, mem_read, rf_wr_sel=1.
  - STORE 0100011: add, mem_write, no reg_write.
  - BRANCH 1100011: branch=1, srcA rs1, srcB rs2, no writes.
  - JAL 1101111: jump, srcA PC, srcB imm, rf_wr_sel=2.
  - JALR 1100111: jump, srcA rs1, srcB imm, rf_wr_sel=2.
  - Any other opcode: all control bits 0 (treated as bubble); data fields still latched.
- Hazard (combinational):
  - Condition: stall = ID_EX_MEM_READ && ID_EX_RD!=0 && (ID_EX_RD==rs1 && opcode uses rs1 || ID_EX_RD==rs2 && opcode uses rs2).
  - rs1 users: OP, OP_IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 users: OP, STORE, BRANCH.
  - On stall: PC_WRITE=0, IF_ID_WRITE=0; at next posedge a bubble enters ID/EX (REG_WRITE, MEM_READ, MEM_WRITE, BRANCH, JUMP = 0).
  - Stall lasts exactly one cycle per load-use pair.
- Flush:
  - FLUSH=1 loads a bubble into ID/EX at next posedge.
  - PC_WRITE=1 and IF_ID_WRITE=1 regardless of stall (flush wins over stall).
- ID/EX latency: 1 cycle. Every field updates on every posedge; no hold state.

Decomposition:
- Package otter_pkg:
  - Opcode constants.
  - alu_fun enum (ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, OR=0110, AND=0111, SUB=1000, SRA=1101).
  - srcA/srcB/rf_wr_sel encodings.
  - ID/EX control struct.
- One sub-module, reg_file (32x32, bypass, x0 logic); decoder, immgen and hazard logic stay inline.

Test Plan:
- RESET high 2 cycles -> all ID_EX_* =0, PC_WRITE=1, IF_ID_WRITE=1; reading x5 returns 0.
- IR=0xFFF00093 (addi x1,x0,-1) -> next cycle ID_EX_IMM=0xFFFFFFFF, SRCB_SEL=1, REG_WRITE=1, RD=1, ALU_FUN=0000.
- WB_WE=1, WB_RD=3, WB_DATA=0xDEADBEEF while decoding add x4,x3,x3 -> ID_EX_RS1_DATA=ID_EX_RS2_DATA=0xDEADBEEF (bypass). WB_RD=0 -> x0 still 0.
- lw x2,0(x1) followed by add x3,x2,x2:
  - add held one cycle with PC_WRITE=0 and IF_ID_WRITE=0.
  - Bubble appears in ID/EX (REG_WRITE=0).
  - Next cycle add issues.
- Stall and FLUSH asserted in the same cycle -> PC_WRITE=1, ID/EX bubble.
- IR=0xFFFFFFFF (invalid opcode) -> all control bits 0.
